// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl - main control FSM for the multicycle MIPS datapath.
//
// Sequences fetch / decode / execute / memory / write-back over several
// cycles and drives every datapath mux select and write enable. Memory
// states (FETCH, MEMRD, MEMWR) stall until mem_ready; a bounded wait
// counter aborts to FETCH with a mem_err pulse if memory never answers.
//
// Ports:
//   clk, reset_n          clock (rising edge), async active-low reset
//   opcode, func          IR[31:26], IR[5:0]; used in DECODE/MEMADR/IEXEC
//   zero                  ALU zero flag (consumed by the PC logic through
//                         pc_write_cond, not by the FSM itself)
//   mem_ready             memory completes the current access this cycle
//   pc_write .. pc_source datapath controls (see field comments below)
//   illegal_op, mem_err   one-cycle error pulses
//   state                 current state code, for debug
//
// Handshake: a memory access is requested by mem_read/mem_write and is
// complete in the cycle mem_ready is high; the request is held (state does
// not advance) while mem_ready is low.
//
// Outputs are decoded from the state register (plus mem_ready in FETCH,
// and the timeout condition), so they are valid in the same cycle as the
// state. All outputs are forced to 0 while reset_n is low.

module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic       mem_err,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXEC  = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11,
    S_JR     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] wait_cnt;
  logic          wait_state;
  logic          timeout;
  logic          bad_op;

  // ZERO is only meaningful to the PC write logic outside this block.
  logic unused_zero;
  assign unused_zero = zero;

  assign wait_state = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                      (state_q == S_MEMWR);
  assign timeout    = wait_state && !mem_ready && (wait_cnt == WAIT_LAST);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    bad_op  = 1'b0;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:     state_d = S_MEMADR;
          OP_RTYPE:         state_d = (func == FN_JR) ? S_JR : S_REXEC;
          OP_BEQ:           state_d = S_BRANCH;
          OP_J:             state_d = S_JUMP;
          OP_ADDI, OP_ANDI: state_d = S_IEXEC;
          default: begin
            state_d = S_FETCH;
            bad_op  = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_REXEC:  state_d = S_RWB;
      S_IEXEC:  state_d = S_IWB;
      default:  state_d = S_FETCH;  // write-back/PC states and codes 13-15
    endcase
    if (timeout) state_d = S_FETCH;
  end

  // State and wait counter. The counter also clears on a FETCH timeout,
  // where the state code itself does not change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (wait_state && !mem_ready && !timeout && (state_d == state_q))
        wait_cnt <= wait_cnt + 1'b1;
      else
        wait_cnt <= '0;
    end
  end

  // Output decode
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;        // PC + 4
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: alu_src_b = 2'b11;  // branch target precompute
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = !timeout;     // abandoned store must not write
        iord      = 1'b1;
      end
      S_REXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_RWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      S_JR: begin
        pc_write  = 1'b1;
        pc_source = 2'b11;
      end
      S_IEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = (opcode == OP_ANDI) ? 2'b11 : 2'b00;
      end
      S_IWB: reg_write = 1'b1;
      default: ;
    endcase
    illegal_op = bad_op;
    mem_err    = timeout;
    state      = state_q;

    if (!reset_n) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_source     = 2'b00;
      illegal_op    = 1'b0;
      mem_err       = 1'b0;
      state         = 4'd0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl - directed self-checking bench for multicycle_ctrl.
// Each step compares {state, control word} against a hand-built expected
// value. Control word bit order (MSB..LSB):
//   pc_write pc_write_cond iord mem_read mem_write ir_write mem_to_reg
//   reg_dst reg_write alu_src_a alu_src_b[1:0] alu_op[1:0] pc_source[1:0]
//   illegal_op mem_err
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] opcode;
  logic [5:0] func;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic       illegal_op, mem_err;
  logic [3:0] state;

  int n_checks = 0;
  int n_pass   = 0;

  multicycle_ctrl #(.MEM_TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .func(func),
    .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .illegal_op(illegal_op), .mem_err(mem_err),
    .state(state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // expected-value builder
  function automatic logic [17:0] ctl(
    input logic pcw, pcwc, io, mr, mw, irw, m2r, rd, rw, asa,
    input logic [1:0] asb, aop, pcs,
    input logic ill, err);
    return {pcw, pcwc, io, mr, mw, irw, m2r, rd, rw, asa, asb, aop, pcs, ill, err};
  endfunction

  localparam logic [17:0] C_F0  = 18'b0_0_0_1_0_0_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] C_F1  = 18'b1_0_0_1_0_1_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] C_DEC = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
  localparam logic [17:0] C_ILL = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_1_0;
  localparam logic [17:0] C_MA  = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [17:0] C_MR  = 18'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] C_MWB = 18'b0_0_0_0_0_0_1_0_1_0_00_00_00_0_0;
  localparam logic [17:0] C_MW  = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] C_MWT = 18'b0_0_1_0_0_0_0_0_0_0_00_00_00_0_1;
  localparam logic [17:0] C_RX  = 18'b0_0_0_0_0_0_0_0_0_1_00_10_00_0_0;
  localparam logic [17:0] C_RWB = 18'b0_0_0_0_0_0_0_1_1_0_00_00_00_0_0;
  localparam logic [17:0] C_BR  = 18'b0_1_0_0_0_0_0_0_0_1_00_01_01_0_0;
  localparam logic [17:0] C_J   = 18'b1_0_0_0_0_0_0_0_0_0_00_00_10_0_0;
  localparam logic [17:0] C_JR  = 18'b1_0_0_0_0_0_0_0_0_0_00_00_11_0_0;
  localparam logic [17:0] C_IXA = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [17:0] C_IXN = 18'b0_0_0_0_0_0_0_0_0_1_10_11_00_0_0;
  localparam logic [17:0] C_IWB = 18'b0_0_0_0_0_0_0_0_1_0_00_00_00_0_0;

  logic [21:0] observed;
  assign observed = {state, pc_write, pc_write_cond, iord, mem_read, mem_write,
                     ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                     alu_src_b, alu_op, pc_source, illegal_op, mem_err};

  // scoreboard check
  task automatic check(input string tag, input logic [21:0] got,
                       input logic [21:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got state=%0d ctl=%b, expected state=%0d ctl=%b",
                  tag, got[21:18], got[17:0], exp[21:18], exp[17:0]);
  endtask

  // driver: inputs are set at posedge+1; compare at posedge+2, then
  // advance to the next posedge+1.
  task automatic step(input string tag, input logic [3:0] es,
                      input logic [17:0] ec);
    #1;
    check(tag, observed, {es, ec});
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [5:0] op, input logic [5:0] fn);
    opcode    = op;
    func      = fn;
    mem_ready = 1'b1;
  endtask

  initial begin
    reset_n   = 1'b0;
    opcode    = 6'b000000;
    func      = 6'b100000;
    zero      = 1'b0;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    step("rst_all_zero", 4'd0, 18'd0);
    step("rst_all_zero2", 4'd0, 18'd0);

    // add with three stall cycles in FETCH
    mem_ready = 1'b0;
    reset_n   = 1'b1;
    step("add_f_wait0", 4'd0, C_F0);
    step("add_f_wait1", 4'd0, C_F0);
    step("add_f_wait2", 4'd0, C_F0);
    mem_ready = 1'b1;
    step("add_fetch",  4'd0, C_F1);
    step("add_decode", 4'd1, C_DEC);
    step("add_rexec",  4'd6, C_RX);
    step("add_rwb",    4'd7, C_RWB);

    // reset asserted in the middle of REXEC
    step("rr_fetch",  4'd0, C_F1);
    step("rr_decode", 4'd1, C_DEC);
    #1;
    check("rr_in_rexec", observed, {4'd6, C_RX});
    reset_n = 1'b0;
    #1;
    check("rr_zero", observed, 22'd0);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    reset_n   = 1'b1;
    #1;
    check("rr_release", observed, {4'd0, C_F0});
    @(posedge clk); #1;

    // lw, with one stall cycle in MEMRD
    instr(6'b100011, 6'b000000);
    step("lw_fetch",  4'd0, C_F1);
    step("lw_decode", 4'd1, C_DEC);
    step("lw_memadr", 4'd2, C_MA);
    mem_ready = 1'b0;
    step("lw_memrd_wait", 4'd3, C_MR);
    mem_ready = 1'b1;
    step("lw_memrd",  4'd3, C_MR);
    step("lw_memwb",  4'd4, C_MWB);

    // beq, zero=1 then zero=0
    for (int z = 1; z >= 0; z--) begin
      zero = z[0];
      instr(6'b000100, 6'b000000);
      step("beq_fetch",  4'd0, C_F1);
      step("beq_decode", 4'd1, C_DEC);
      step("beq_branch", 4'd8, C_BR);
    end

    // jr
    instr(6'b000000, 6'b001000);
    step("jr_fetch",  4'd0, C_F1);
    step("jr_decode", 4'd1, C_DEC);
    step("jr_jr",     4'd12, C_JR);

    // j
    instr(6'b000010, 6'b000000);
    step("j_fetch",  4'd0, C_F1);
    step("j_decode", 4'd1, C_DEC);
    step("j_jump",   4'd9, C_J);

    // addi / andi
    instr(6'b001000, 6'b000000);
    step("addi_fetch",  4'd0, C_F1);
    step("addi_decode", 4'd1, C_DEC);
    step("addi_iexec",  4'd10, C_IXA);
    step("addi_iwb",    4'd11, C_IWB);
    instr(6'b001100, 6'b000000);
    step("andi_fetch",  4'd0, C_F1);
    step("andi_decode", 4'd1, C_DEC);
    step("andi_iexec",  4'd10, C_IXN);
    step("andi_iwb",    4'd11, C_IWB);

    // illegal opcode
    instr(6'b111111, 6'b000000);
    step("ill_fetch",  4'd0, C_F1);
    step("ill_decode", 4'd1, C_ILL);
    mem_ready = 1'b0;
    step("ill_back_fetch", 4'd0, C_F0);

    // sw with memory never ready: 16 cycles in MEMWR, last one aborts
    instr(6'b101011, 6'b000000);
    step("sw_fetch",  4'd0, C_F1);
    step("sw_decode", 4'd1, C_DEC);
    step("sw_memadr", 4'd2, C_MA);
    mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) step("sw_memwr_wait", 4'd5, C_MW);
    step("sw_timeout", 4'd5, C_MWT);
    step("sw_after_timeout", 4'd0, C_F0);

    // sw completing normally
    instr(6'b101011, 6'b000000);
    step("sw2_fetch",  4'd0, C_F1);
    step("sw2_decode", 4'd1, C_DEC);
    step("sw2_memadr", 4'd2, C_MA);
    step("sw2_memwr",  4'd5, C_MW);
    mem_ready = 1'b0;
    step("sw2_done",   4'd0, C_F0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
